// File: rtl/serpent_req_arbiter.sv
// Round-robin front end that shares one serpent_top core between N_REQ requesters,
// holding job inputs stable, watching for a stuck core and returning tagged results.
module serpent_req_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [N_REQ-1:0]     i_req_valid,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic [256*N_REQ-1:0] i_req_key,
  input  logic [128*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]     i_req_en_de,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic [127:0]         o_rsp_data,
  output logic                 o_rsp_err,
  output logic                 o_core_key_valid,
  output logic                 o_core_en_de,
  output logic [255:0]         o_core_key,
  output logic [127:0]         o_core_data,
  input  logic [127:0]         i_core_data,
  input  logic                 i_core_data_valid,
  output logic                 o_busy,
  output logic [2:0]           o_dbg_state
);

  // Handshakes: a request transfers on a cycle where i_req_valid[r] and o_req_ready[r]
  // are both high; a response transfers on a cycle where o_rsp_valid and i_rsp_ready are both high.

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] BUSY  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [WD_W-1:0] wdog;

  logic [ID_W-1:0] winner;
  logic            found;
  logic [255:0]    sel_key;
  logic [127:0]    sel_data;
  logic            sel_en_de;

  // Cyclic search from rr_ptr: first the upper part, then wrap to the lower part.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      if (!found && i_req_valid[r] && (r >= int'(rr_ptr))) begin
        found  = 1'b1;
        winner = ID_W'(r);
      end
    end
    for (int r = 0; r < N_REQ; r++) begin
      if (!found && i_req_valid[r] && (r < int'(rr_ptr))) begin
        found  = 1'b1;
        winner = ID_W'(r);
      end
    end
  end

  always_comb begin
    sel_key   = '0;
    sel_data  = '0;
    sel_en_de = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      if (winner == ID_W'(r)) begin
        sel_key   = i_req_key[r*256 +: 256];
        sel_data  = i_req_data[r*128 +: 128];
        sel_en_de = i_req_en_de[r];
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    for (int r = 0; r < N_REQ; r++) begin
      o_req_ready[r] = (state == IDLE) && found && (winner == ID_W'(r));
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      wdog         <= '0;
      o_core_key   <= '0;
      o_core_data  <= '0;
      o_core_en_de <= 1'b0;
      o_rsp_id     <= '0;
      o_rsp_data   <= '0;
      o_rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            o_core_key   <= sel_key;
            o_core_data  <= sel_data;
            o_core_en_de <= sel_en_de;
            o_rsp_id     <= winner;
            rr_ptr       <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= BUSY;
        end
        BUSY: begin
          // A result arriving on the watchdog's final cycle still counts as success.
          if (i_core_data_valid) begin
            o_rsp_data <= i_core_data;
            o_rsp_err  <= 1'b0;
            state      <= DRAIN;
          end else if (wdog == WD_LAST) begin
            o_rsp_data <= '0;
            o_rsp_err  <= 1'b1;
            state      <= DRAIN;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DRAIN: state <= RESP;
        RESP: begin
          if (i_rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_core_key_valid = (state == ISSUE);
  assign o_rsp_valid      = (state == RESP);
  assign o_busy           = (state != IDLE);
  assign o_dbg_state      = state;

endmodule
